// File: rtl/uart_core.sv
// Single-clock UART transceiver with internal bit timing, configurable framing,
// valid/ready byte handshakes and framing/parity/overrun reporting.
module uart_core #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam int CW = $clog2(2 * CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF      = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic HAS_PARITY = (PARITY != 0);
    localparam logic ODD_PARITY = (PARITY == 1);

    // ------------------------------------------------------------------
    // Transmitter
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP
    } tx_state_t;

    tx_state_t            tx_state_reg, tx_state_next;
    logic [CW-1:0]        tx_cnt_reg, tx_cnt_next;
    logic [BW-1:0]        tx_bit_reg, tx_bit_next;
    logic [DATA_BITS-1:0] tx_shift_reg, tx_shift_next;
    logic                 tx_par_reg, tx_par_next;
    logic                 tx_out_reg, tx_out_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_reg <= TX_IDLE;
            tx_cnt_reg   <= '0;
            tx_bit_reg   <= '0;
            tx_shift_reg <= '0;
            tx_par_reg   <= 1'b0;
            tx_out_reg   <= 1'b1;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_cnt_reg   <= tx_cnt_next;
            tx_bit_reg   <= tx_bit_next;
            tx_shift_reg <= tx_shift_next;
            tx_par_reg   <= tx_par_next;
            tx_out_reg   <= tx_out_next;
        end
    end

    // tx_out is registered from the next-state decision so the pin changes
    // on the same edge as the state, without combinational glitches.
    always_comb begin
        tx_state_next = tx_state_reg;
        tx_cnt_next   = tx_cnt_reg + 1'b1;
        tx_bit_next   = tx_bit_reg;
        tx_shift_next = tx_shift_reg;
        tx_par_next   = tx_par_reg;
        tx_out_next   = tx_out_reg;
        case (tx_state_reg)
            TX_IDLE: begin
                tx_cnt_next = '0;
                tx_out_next = 1'b1;
                if (tx_valid) begin
                    tx_shift_next = tx_data;
                    tx_par_next   = (^tx_data) ^ ODD_PARITY;
                    tx_bit_next   = '0;
                    tx_out_next   = 1'b0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_out_next   = tx_shift_reg[0];
                    tx_state_next = TX_DATA;
                end
            end
            TX_DATA: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_shift_next = tx_shift_reg >> 1;
                    tx_bit_next   = tx_bit_reg + 1'b1;
                    if (tx_bit_reg == DATA_LAST) begin
                        tx_state_next = HAS_PARITY ? TX_PARITY : TX_STOP;
                        tx_out_next   = HAS_PARITY ? tx_par_reg : 1'b1;
                    end else begin
                        tx_out_next = tx_shift_reg[1];
                    end
                end
            end
            TX_PARITY: begin
                if (tx_cnt_reg == BIT_LAST) begin
                    tx_cnt_next   = '0;
                    tx_out_next   = 1'b1;
                    tx_state_next = TX_STOP;
                end
            end
            TX_STOP: begin
                if (tx_cnt_reg == STOP_LAST) begin
                    tx_cnt_next   = '0;
                    tx_out_next   = 1'b1;
                    tx_state_next = TX_IDLE;
                end
            end
            default: tx_state_next = TX_IDLE;
        endcase
    end

    assign tx_ready = (tx_state_reg == TX_IDLE);
    assign tx_out   = tx_out_reg;

    // ------------------------------------------------------------------
    // Receiver front end: two-flop synchroniser plus one delayed copy for
    // falling-edge detection; all preset high to match an idle line.
    // ------------------------------------------------------------------
    logic sync1_reg, sync2_reg, rxs_prev_reg;
    logic rxs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg    <= 1'b1;
            sync2_reg    <= 1'b1;
            rxs_prev_reg <= 1'b1;
        end else begin
            sync1_reg    <= rx_in;
            sync2_reg    <= sync1_reg;
            rxs_prev_reg <= sync2_reg;
        end
    end

    assign rxs = sync2_reg;

    // ------------------------------------------------------------------
    // Receiver FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH
    } rx_state_t;

    rx_state_t            rx_state_reg, rx_state_next;
    logic [CW-1:0]        rx_cnt_reg, rx_cnt_next;
    logic [BW-1:0]        rx_bit_reg, rx_bit_next;
    logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
    logic                 rx_par_reg, rx_par_next;
    logic                 frame_done, frame_perr, frame_ferr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state_reg <= RX_IDLE;
            rx_cnt_reg   <= '0;
            rx_bit_reg   <= '0;
            rx_shift_reg <= '0;
            rx_par_reg   <= 1'b0;
        end else begin
            rx_state_reg <= rx_state_next;
            rx_cnt_reg   <= rx_cnt_next;
            rx_bit_reg   <= rx_bit_next;
            rx_shift_reg <= rx_shift_next;
            rx_par_reg   <= rx_par_next;
        end
    end

    always_comb begin
        rx_state_next = rx_state_reg;
        rx_cnt_next   = rx_cnt_reg + 1'b1;
        rx_bit_next   = rx_bit_reg;
        rx_shift_next = rx_shift_reg;
        rx_par_next   = rx_par_reg;
        frame_done    = 1'b0;
        frame_ferr    = 1'b0;
        frame_perr    = HAS_PARITY && (rx_par_reg != ((^rx_shift_reg) ^ ODD_PARITY));
        case (rx_state_reg)
            RX_IDLE: begin
                rx_cnt_next = '0;
                if (rxs_prev_reg && !rxs) begin
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                // Mid-start-bit check; a line already back high was a glitch.
                if (rx_cnt_reg == HALF) begin
                    rx_cnt_next   = '0;
                    rx_bit_next   = '0;
                    rx_state_next = rxs ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_shift_next = {rxs, rx_shift_reg[DATA_BITS-1:1]};
                    rx_bit_next   = rx_bit_reg + 1'b1;
                    if (rx_bit_reg == DATA_LAST) begin
                        rx_state_next = HAS_PARITY ? RX_PARITY : RX_STOP;
                    end
                end
            end
            RX_PARITY: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    rx_par_next   = rxs;
                    rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_reg == BIT_LAST) begin
                    rx_cnt_next   = '0;
                    frame_done    = 1'b1;
                    frame_ferr    = !rxs;
                    rx_state_next = rxs ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                // A break must release before another start can be detected.
                rx_cnt_next = '0;
                if (rxs) begin
                    rx_state_next = RX_IDLE;
                end
            end
            default: rx_state_next = RX_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Receive holding register and handshake
    // ------------------------------------------------------------------
    logic [DATA_BITS-1:0] rx_data_reg;
    logic                 rx_valid_reg, rx_perr_reg, rx_ferr_reg, rx_overrun_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_reg    <= '0;
            rx_valid_reg   <= 1'b0;
            rx_perr_reg    <= 1'b0;
            rx_ferr_reg    <= 1'b0;
            rx_overrun_reg <= 1'b0;
        end else begin
            rx_overrun_reg <= 1'b0;
            if (frame_done && (!rx_valid_reg || rx_ready)) begin
                rx_data_reg  <= rx_shift_reg;
                rx_perr_reg  <= frame_perr;
                rx_ferr_reg  <= frame_ferr;
                rx_valid_reg <= 1'b1;
            end else if (frame_done) begin
                rx_overrun_reg <= 1'b1;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

    assign rx_data       = rx_data_reg;
    assign rx_valid      = rx_valid_reg;
    assign rx_parity_err = rx_perr_reg;
    assign rx_frame_err  = rx_ferr_reg;
    assign rx_overrun    = rx_overrun_reg;

endmodule

// File: tb/tb_uart_core.sv
// Randomized self-checking bench for uart_core (16 clk/bit, 8 data bits,
// even parity, one stop bit) against a frame-level reference model.
module tb_uart_core;

    localparam int CPB   = 16;
    localparam int DBITS = 8;
    localparam int PMODE = 2;
    localparam int SBITS = 1;
    localparam int NBITS = 1 + DBITS + ((PMODE != 0) ? 1 : 0) + SBITS;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx_out;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_overrun;

    logic loop_sel = 1'b1;
    logic rx_drv = 1'b1;
    assign rx_in = loop_sel ? tx_out : rx_drv;

    uart_core #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DBITS),
        .PARITY      (PMODE),
        .STOP_BITS   (SBITS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .tx_out       (tx_out),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .rx_parity_err(rx_parity_err),
        .rx_frame_err (rx_frame_err),
        .rx_overrun   (rx_overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } frame_t;

    frame_t got_q[$];
    frame_t exp_q[$];
    int     ovr_cnt = 0;
    int     vec_cnt = 0;
    int     err_cnt = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: correct parity bit for a payload, and the wire level
    // of bit position i within a frame (0 = start bit).
    function automatic logic model_parity(input logic [7:0] d);
        logic odd_ones;
        odd_ones = ($countones(d) % 2) == 1;
        return (PMODE == 1) ? !odd_ones : odd_ones;
    endfunction

    function automatic logic model_bit(input logic [7:0] d, input int i);
        if (i == 0) return 1'b0;
        if (i <= DBITS) return d[i-1];
        if (PMODE != 0 && i == DBITS + 1) return model_parity(d);
        return 1'b1;
    endfunction

    function automatic frame_t model_rx(input logic [7:0] d, input logic par, input logic stop);
        frame_t f;
        f.d  = d;
        f.pe = (PMODE != 0) && (par != model_parity(d));
        f.fe = !stop;
        return f;
    endfunction

    always @(negedge clk) begin
        if (rst_n && rx_valid && rx_ready) begin
            frame_t f;
            f.d  = rx_data;
            f.pe = rx_parity_err;
            f.fe = rx_frame_err;
            got_q.push_back(f);
        end
        if (rst_n && rx_overrun) ovr_cnt++;
    end

    // Send one byte and check every bit of the emitted frame mid-bit,
    // plus how long tx_ready stays low.
    task automatic tx_send(input logic [7:0] d);
        int e;
        e = 0;
        tx_data  = d;
        tx_valid = 1'b1;
        while (!tx_ready && e < 1000) begin
            @(posedge clk); #1; e++;
        end
        check_value("tx_ready_wait", {31'd0, tx_ready}, 32'd1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        check_value("tx_start_edge", {31'd0, tx_out}, 32'd0);
        check_value("tx_ready_drop", {31'd0, tx_ready}, 32'd0);
        e = 0;
        for (int i = 0; i < NBITS; i++) begin
            repeat (CPB * i + CPB / 2 - e) @(posedge clk);
            #1;
            e = CPB * i + CPB / 2;
            check_value($sformatf("tx_bit%0d", i), {31'd0, tx_out}, {31'd0, model_bit(d, i)});
        end
        while (!tx_ready && e < 1000) begin
            @(posedge clk); #1; e++;
        end
        check_value("tx_ready_low_cycles", e, NBITS * CPB);
        $display("tx byte 0x%02h sent", d);
    endtask

    // Drive a hand-built frame onto rx_in; caller is at posedge+1.
    task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop);
        for (int i = 0; i < NBITS; i++) begin
            if (i == 0) rx_drv = 1'b0;
            else if (i <= DBITS) rx_drv = d[i-1];
            else if (PMODE != 0 && i == DBITS + 1) rx_drv = par;
            else rx_drv = stop;
            repeat (CPB) @(posedge clk);
            #1;
        end
        rx_drv = 1'b1;
    endtask

    task automatic compare_frames(input string tag);
        check_value({tag, "_count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            frame_t g;
            frame_t x;
            g = got_q.pop_front();
            x = exp_q.pop_front();
            $display("rx frame data=0x%02h perr=%0d ferr=%0d", g.d, g.pe, g.fe);
            check_value({tag, "_data"}, {24'd0, g.d}, {24'd0, x.d});
            check_value({tag, "_perr"}, {31'd0, g.pe}, {31'd0, x.pe});
            check_value({tag, "_ferr"}, {31'd0, g.fe}, {31'd0, x.fe});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       found;
        int         k;
        int         ovr_base;

        repeat (3) @(posedge clk);
        #1;
        check_value("rst_tx_out", {31'd0, tx_out}, 32'd1);
        check_value("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_value("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check_value("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check_value("rst_flags", {29'd0, rx_parity_err, rx_frame_err, rx_overrun}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Loopback: fixed 0xA5, 0x3C, 0xFF then random bytes, back-to-back.
        ovr_base = ovr_cnt;
        tx_send(8'hA5);
        exp_q.push_back(model_rx(8'hA5, model_parity(8'hA5), 1'b1));
        tx_send(8'h3C);
        exp_q.push_back(model_rx(8'h3C, model_parity(8'h3C), 1'b1));
        tx_send(8'hFF);
        exp_q.push_back(model_rx(8'hFF, model_parity(8'hFF), 1'b1));
        for (int n = 0; n < 5; n++) begin
            d = 8'($urandom_range(0, 255));
            tx_send(d);
            exp_q.push_back(model_rx(d, model_parity(d), 1'b1));
        end
        repeat (CPB) @(posedge clk);
        #1;
        compare_frames("loopback");
        check_value("loopback_overrun", ovr_cnt - ovr_base, 0);

        // Receive latency from the start-bit falling edge on rx_in.
        loop_sel = 1'b0;
        rx_drv   = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        d = 8'($urandom_range(0, 255));
        found = 1'b0;
        k = 0;
        fork
            drive_frame(d, model_parity(d), 1'b1);
            begin
                while (!found && k < 400) begin
                    @(posedge clk); #1; k++;
                    if (rx_valid) found = 1'b1;
                end
            end
        join
        check_value("rx_latency", k, 1 + 2 + (1 + DBITS + 1) * CPB + CPB / 2 + 1);
        exp_q.push_back(model_rx(d, model_parity(d), 1'b1));
        repeat (4) @(posedge clk);
        #1;
        compare_frames("latency");

        // Parity error: 0x3C with the parity bit forced to 1.
        drive_frame(8'h3C, 1'b1, 1'b1);
        exp_q.push_back(model_rx(8'h3C, 1'b1, 1'b1));
        repeat (4) @(posedge clk);
        #1;
        compare_frames("parity_err");

        // Break: 20 bit times low gives exactly one frame.
        rx_drv = 1'b0;
        repeat (20 * CPB) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        exp_q.push_back(model_rx(8'h00, 1'b0, 1'b0));
        compare_frames("break");

        // Overrun: two frames while the host is not ready.
        rx_ready = 1'b0;
        ovr_base = ovr_cnt;
        drive_frame(8'h11, model_parity(8'h11), 1'b1);
        drive_frame(8'h22, model_parity(8'h22), 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check_value("ovr_valid", {31'd0, rx_valid}, 32'd1);
        check_value("ovr_held_data", {24'd0, rx_data}, 32'h11);
        check_value("ovr_pulses", ovr_cnt - ovr_base, 1);
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_value("ovr_consumed", {31'd0, rx_valid}, 32'd0);
        exp_q.push_back(model_rx(8'h11, model_parity(8'h11), 1'b1));
        compare_frames("overrun");

        // Glitch: a 4-cycle low pulse is ignored, a real frame still follows.
        rx_drv = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_drv = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check_value("glitch_valid", {31'd0, rx_valid}, 32'd0);
        compare_frames("glitch");
        d = 8'($urandom_range(0, 255));
        drive_frame(d, model_parity(d), 1'b1);
        exp_q.push_back(model_rx(d, model_parity(d), 1'b1));
        repeat (4) @(posedge clk);
        #1;
        compare_frames("post_glitch");

        // Asynchronous reset in the middle of a transmit frame.
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        repeat (40) @(posedge clk);
        #3;
        check_value("pre_reset_busy", {31'd0, tx_ready}, 32'd0);
        rst_n = 1'b0;
        #1;
        check_value("async_rst_tx_out", {31'd0, tx_out}, 32'd1);
        check_value("async_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check_value("async_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        check_value("post_rst_tx_out", {31'd0, tx_out}, 32'd1);
        check_value("post_rst_tx_ready", {31'd0, tx_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
